interconn_rxbuf: RTL and testbench

Receive-side buffer for one MVU, sitting directly downstream of the MVU interconnect crossbar. It captures the crossbar's registered per-MVU output (`recv_en`/`recv_word`) every cycle into a small FIFO, because the crossbar has no backpressure. It then drains the words into the MVU's data memory through a valid/ready write port, generating a circular write address over a configured region. One instance per MVU receive lane.

---
 rtl/interconn_rxbuf_pkg.sv | 7 +
 rtl/interconn_rxbuf_if.sv | 28 ++
 rtl/interconn_rxbuf_fifo_sync.sv | 56 +++++
 rtl/interconn_rxbuf.sv | 72 +++++++
 tb/tb_interconn_rxbuf.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/interconn_rxbuf_pkg.sv
// Shared constants for the MVU receive-side buffer.
// The word width matches the crossbar lane width so both sides agree on one value.
package interconn_rxbuf_pkg;
    localparam int MVU_WORD_W  = 128;
    localparam int RXBUF_DEPTH = 8;
    localparam int RXBUF_AW    = 10;
endpackage

// File: rtl/interconn_rxbuf_if.sv
// Receive lane (crossbar -> buffer) and memory write port (buffer -> data memory).
interface interconn_rxbuf_if
    import interconn_rxbuf_pkg::*;
#(
    parameter int W  = MVU_WORD_W,
    parameter int AW = RXBUF_AW
);
    // recv_*: no backpressure, a word is offered whenever recv_en is high.
    // mem_wr_*: a write transfers at a rising edge where mem_wr_en && mem_wr_ready;
    // while mem_wr_en is high, addr/data hold until accepted, and mem_wr_en never
    // depends on mem_wr_ready (ready may depend on en).
    logic          recv_en;
    logic [W-1:0]  recv_word;
    logic          mem_wr_en;
    logic [AW-1:0] mem_wr_addr;
    logic [W-1:0]  mem_wr_data;
    logic          mem_wr_ready;

    modport master (
        input  recv_en, recv_word, mem_wr_ready,
        output mem_wr_en, mem_wr_addr, mem_wr_data
    );

    modport slave (
        output recv_en, recv_word, mem_wr_ready,
        input  mem_wr_en, mem_wr_addr, mem_wr_data
    );
endinterface

// File: rtl/interconn_rxbuf_fifo_sync.sv
// Generic show-ahead synchronous FIFO with synchronous flush.
// A push during flush lands in the freshly emptied FIFO.
module fifo_sync
    import interconn_rxbuf_pkg::*;
#(
    parameter int  W     = MVU_WORD_W,
    parameter int  DEPTH = RXBUF_DEPTH,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty && !flush;
    // A pop frees a slot in the same cycle, so a full FIFO can still take a push.
    assign do_push = push && (flush || !full || do_pop);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= do_push ? PW'(1) : '0;
            count  <= do_push ? CW'(1) : '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[flush ? '0 : wr_ptr] <= din;
    end

    // Storage is not reset; masking keeps the head at zero while empty.
    assign dout = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/interconn_rxbuf.sv
// Receive buffer for one MVU lane: captures crossbar words into a FIFO and
// drains them into data memory over a circular address region.
module interconn_rxbuf
    import interconn_rxbuf_pkg::*;
#(
    parameter int  W     = MVU_WORD_W,
    parameter int  DEPTH = RXBUF_DEPTH,
    parameter int  AW    = RXBUF_AW,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    clr,
    interconn_rxbuf_if.master       bus,
    input  logic                    cfg_load,
    input  logic [AW-1:0]           cfg_base,
    input  logic [AW-1:0]           cfg_len,
    output logic [CW-1:0]           count,
    output logic                    overflow,
    output logic                    wrap
);
    logic          full;
    logic          empty;
    logic          pop_fire;
    logic          drop;
    logic [AW-1:0] addr;
    logic [AW-1:0] base;
    logic [AW-1:0] len;
    logic [AW-1:0] last;

    assign bus.mem_wr_en   = !empty;
    assign bus.mem_wr_addr = addr;
    // cfg_load cancels a same-cycle pop; the flush owns the FIFO that cycle.
    assign pop_fire = !empty && bus.mem_wr_ready && !cfg_load;
    assign drop     = bus.recv_en && full && !pop_fire && !cfg_load;
    assign last     = base + len;

    fifo_sync #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .clr   (clr),
        .flush (cfg_load),
        .push  (bus.recv_en),
        .pop   (pop_fire),
        .din   (bus.recv_word),
        .dout  (bus.mem_wr_data),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            addr     <= '0;
            base     <= '0;
            len      <= '0;
            overflow <= 1'b0;
            wrap     <= 1'b0;
        end else if (cfg_load) begin
            addr     <= cfg_base;
            base     <= cfg_base;
            len      <= cfg_len;
            overflow <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            wrap <= pop_fire && (addr == last);
            if (pop_fire) addr <= (addr == last) ? base : addr + AW'(1);
            if (drop) overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_interconn_rxbuf.sv
// Bench for interconn_rxbuf: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_interconn_rxbuf;
    import interconn_rxbuf_pkg::*;

    localparam int W     = 128;
    localparam int DEPTH = 8;
    localparam int AW    = 10;
    localparam int CW    = $clog2(DEPTH) + 1;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          clr;
    logic          cfg_load;
    logic [AW-1:0] cfg_base;
    logic [AW-1:0] cfg_len;
    logic [CW-1:0] count;
    logic          overflow;
    logic          wrap;

    interconn_rxbuf_if #(.W(W), .AW(AW)) bus ();

    interconn_rxbuf #(.W(W), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk      (clk),
        .clr      (clr),
        .bus      (bus),
        .cfg_load (cfg_load),
        .cfg_base (cfg_base),
        .cfg_len  (cfg_len),
        .count    (count),
        .overflow (overflow),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard / reference model ----------------
    int           checks   = 0;
    int           failures = 0;
    logic [W-1:0] exp_q[$];
    int unsigned  m_base;
    int unsigned  m_len;
    int unsigned  m_n;
    logic         m_ovf;
    logic         m_wrap;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        exp_q.delete();
        m_base = 0;
        m_len  = 0;
        m_n    = 0;
        m_ovf  = 1'b0;
        m_wrap = 1'b0;
    endtask

    // Address of the n-th write since the last config, modulo the region and 2^AW.
    function automatic logic [AW-1:0] m_addr();
        return AW'((m_base + (m_n % (m_len + 1))) % (1 << AW));
    endfunction

    task automatic model_step(input logic en, input logic [W-1:0] word, input logic rdy,
                              input logic ld, input logic [AW-1:0] b, input logic [AW-1:0] l);
        logic pop;
        pop = (exp_q.size() != 0) && rdy && !ld;
        if (ld) begin
            exp_q.delete();
            m_ovf  = 1'b0;
            m_wrap = 1'b0;
            m_base = int'(b);
            m_len  = int'(l);
            m_n    = 0;
            if (en) exp_q.push_back(word);
        end else begin
            m_wrap = pop && ((m_n % (m_len + 1)) == m_len);
            if (pop) begin
                void'(exp_q.pop_front());
                m_n++;
            end
            if (en) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(word);
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic check_model();
        check("mdl_en", W'(bus.mem_wr_en), W'(exp_q.size() != 0));
        check("mdl_count", W'(count), W'(exp_q.size()));
        check("mdl_overflow", W'(overflow), W'(m_ovf));
        check("mdl_wrap", W'(wrap), W'(m_wrap));
        check("mdl_addr", W'(bus.mem_wr_addr), W'(m_addr()));
        if (exp_q.size() != 0) check("mdl_data", bus.mem_wr_data, exp_q[0]);
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge: drive, let the rising edge pass, check at the next falling edge.
    task automatic step(input logic en, input logic [W-1:0] word, input logic rdy,
                        input logic ld, input logic [AW-1:0] b, input logic [AW-1:0] l);
        bus.recv_en      = en;
        bus.recv_word    = word;
        bus.mem_wr_ready = rdy;
        cfg_load         = ld;
        cfg_base         = b;
        cfg_len          = l;
        model_step(en, word, rdy, ld, b, l);
        @(negedge clk);
        check_model();
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, '0, rdy, 1'b0, '0, '0);
    endtask

    function automatic logic [W-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic          ld;
        logic [AW-1:0] base;
        logic [AW-1:0] len;
        logic          en;
        logic [W-1:0]  word;
        logic          rdy;
        logic          x_en;
        logic [AW-1:0] x_addr;
        logic [W-1:0]  x_data;
        int            x_cnt;
        logic          x_wrap;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] w;

        // single word, then a five-write wrap across the top of the address space
        tbl[0] = '{1'b1, 10'h100, 10'd3, 1'b0, 128'h0,    1'b1, 1'b0, 10'h100, 128'h0,    0, 1'b0};
        tbl[1] = '{1'b0, 10'h000, 10'd0, 1'b1, 128'hA5,   1'b1, 1'b1, 10'h100, 128'hA5,   1, 1'b0};
        tbl[2] = '{1'b0, 10'h000, 10'd0, 1'b0, 128'h0,    1'b1, 1'b0, 10'h101, 128'h0,    0, 1'b0};
        tbl[3] = '{1'b1, 10'h3FE, 10'd3, 1'b0, 128'h0,    1'b1, 1'b0, 10'h3FE, 128'h0,    0, 1'b0};
        tbl[4] = '{1'b0, 10'h000, 10'd0, 1'b1, 128'hC01,  1'b1, 1'b1, 10'h3FE, 128'hC01,  1, 1'b0};
        tbl[5] = '{1'b0, 10'h000, 10'd0, 1'b1, 128'hC02,  1'b1, 1'b1, 10'h3FF, 128'hC02,  1, 1'b0};
        tbl[6] = '{1'b0, 10'h000, 10'd0, 1'b1, 128'hC03,  1'b1, 1'b1, 10'h000, 128'hC03,  1, 1'b0};
        tbl[7] = '{1'b0, 10'h000, 10'd0, 1'b1, 128'hC04,  1'b1, 1'b1, 10'h001, 128'hC04,  1, 1'b0};
        tbl[8] = '{1'b0, 10'h000, 10'd0, 1'b1, 128'hC05,  1'b1, 1'b1, 10'h3FE, 128'hC05,  1, 1'b1};
        tbl[9] = '{1'b0, 10'h000, 10'd0, 1'b0, 128'h0,    1'b1, 1'b0, 10'h3FF, 128'h0,    0, 1'b0};

        clr              = 1'b1;
        cfg_load         = 1'b0;
        cfg_base         = '0;
        cfg_len          = '0;
        bus.recv_en      = 1'b0;
        bus.recv_word    = '0;
        bus.mem_wr_ready = 1'b0;
        m_reset();

        #12;
        check("rst_en", W'(bus.mem_wr_en), W'(0));
        check("rst_addr", W'(bus.mem_wr_addr), W'(0));
        check("rst_data", bus.mem_wr_data, W'(0));
        check("rst_count", W'(count), W'(0));
        check("rst_overflow", W'(overflow), W'(0));
        check("rst_wrap", W'(wrap), W'(0));
        @(negedge clk);
        clr = 1'b0;

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].en, tbl[i].word, tbl[i].rdy, tbl[i].ld, tbl[i].base, tbl[i].len);
            check($sformatf("tbl%0d_en", i), W'(bus.mem_wr_en), W'(tbl[i].x_en));
            check($sformatf("tbl%0d_addr", i), W'(bus.mem_wr_addr), W'(tbl[i].x_addr));
            check($sformatf("tbl%0d_count", i), W'(count), W'(tbl[i].x_cnt));
            check($sformatf("tbl%0d_wrap", i), W'(wrap), W'(tbl[i].x_wrap));
            if (tbl[i].x_en) check($sformatf("tbl%0d_data", i), bus.mem_wr_data, tbl[i].x_data);
        end

        // overflow: ten pushes into a stalled FIFO, only the first eight survive
        step(1'b0, '0, 1'b0, 1'b1, 10'h040, 10'd15);
        for (int i = 0; i < 10; i++) step(1'b1, W'(32'hF000 + i), 1'b0, 1'b0, '0, '0);
        check("ovf_count", W'(count), W'(8));
        check("ovf_flag", W'(overflow), W'(1));
        for (int i = 0; i < 8; i++) begin
            check("ovf_drain_data", bus.mem_wr_data, W'(32'hF000 + i));
            idle(1'b1);
        end
        check("ovf_drained_count", W'(count), W'(0));
        check("ovf_sticky", W'(overflow), W'(1));

        // cfg_load with three queued words and a same-cycle push
        for (int i = 0; i < 3; i++) step(1'b1, W'(32'hD000 + i), 1'b0, 1'b0, '0, '0);
        step(1'b1, W'(32'hE0E0), 1'b1, 1'b1, 10'h200, 10'd7);
        check("ld_count", W'(count), W'(1));
        check("ld_addr", W'(bus.mem_wr_addr), W'(10'h200));
        check("ld_overflow", W'(overflow), W'(0));
        check("ld_data", bus.mem_wr_data, W'(32'hE0E0));
        idle(1'b1);

        // full FIFO with simultaneous push and pop
        for (int i = 0; i < 8; i++) step(1'b1, W'(32'hB00 + i), 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, W'(32'hB08 + i), 1'b1, 1'b0, '0, '0);
            check("fpp_count", W'(count), W'(8));
            check("fpp_overflow", W'(overflow), W'(0));
        end
        check("fpp_head", bus.mem_wr_data, W'(32'hB04));
        for (int i = 0; i < 8; i++) idle(1'b1);

        // randomized traffic with backpressure and periodic reconfiguration
        for (int r = 0; r < 3; r++) begin
            step(1'($urandom_range(0, 1)), rand_word(), 1'b1, 1'b1,
                 AW'($urandom_range(0, 1023)), AW'($urandom_range(0, 5)));
            for (int i = 0; i < 120; i++) begin
                w = rand_word();
                step(1'($urandom_range(0, 3) != 0), w, 1'($urandom_range(0, 1)), 1'b0, '0, '0);
            end
            for (int i = 0; i < 10; i++) idle(1'b1);
        end

        // asynchronous clear mid-operation, then the single-address default region
        for (int i = 0; i < 3; i++) step(1'b1, W'(32'h7700 + i), 1'b0, 1'b0, '0, '0);
        bus.recv_en = 1'b0;
        cfg_load    = 1'b0;
        #2 clr = 1'b1;
        #1;
        check("clr_en", W'(bus.mem_wr_en), W'(0));
        check("clr_addr", W'(bus.mem_wr_addr), W'(0));
        check("clr_data", bus.mem_wr_data, W'(0));
        check("clr_count", W'(count), W'(0));
        check("clr_overflow", W'(overflow), W'(0));
        check("clr_wrap", W'(wrap), W'(0));
        #1 clr = 1'b0;
        m_reset();
        step(1'b1, W'(32'h1234), 1'b1, 1'b0, '0, '0);
        step(1'b1, W'(32'h5678), 1'b1, 1'b0, '0, '0);
        check("dflt_addr", W'(bus.mem_wr_addr), W'(0));
        check("dflt_wrap", W'(wrap), W'(1));
        idle(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
